// File: rtl/line_read_buffer_pkg.sv
// Shared types and helpers for the single-line read buffer between the
// data freezer and the burst memory port.
package line_read_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_FILL = 2'd2,
        WR_REQ  = 2'd3
    } lrb_state_t;

    function automatic int offset_width(input int burst_len);
        return $clog2(burst_len);
    endfunction

endpackage

// File: rtl/line_read_buffer_line_store.sv
// Register file holding the words of the buffered line; one synchronous
// write port, one asynchronous read port, no tag or valid state.
module line_read_buffer_line_store #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = 2
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [IDX_WIDTH-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDX_WIDTH-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Word write
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/line_read_buffer.sv
// Single-line read buffer: read misses fetch an aligned burst, later reads in
// the same line hit locally; writes go straight through and patch the line.
module line_read_buffer
    import line_read_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_rd,
    input  logic                  in_wr,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_din,
    output logic [DATA_WIDTH-1:0] in_dout,
    output logic                  in_wait_n,
    output logic                  in_valid,
    output logic                  out_rd,
    output logic                  out_wr,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_din,
    input  logic [DATA_WIDTH-1:0] out_dout,
    input  logic                  out_wait_n,
    input  logic                  out_valid
);

    localparam int OFF_W = offset_width(BURST_LEN);
    localparam int TAG_W = ADDR_WIDTH - OFF_W;

    lrb_state_t            state_r;
    logic                  line_valid_r;
    logic                  flush_pend_r;
    logic [TAG_W-1:0]      tag_r;
    logic [TAG_W-1:0]      req_tag_r;
    logic [OFF_W-1:0]      req_off_r;
    logic [OFF_W-1:0]      cnt_r;

    logic [DATA_WIDTH-1:0] in_dout_r;
    logic                  in_wait_n_r;
    logic                  in_valid_r;
    logic                  out_rd_r;
    logic                  out_wr_r;
    logic [ADDR_WIDTH-1:0] out_addr_r;
    logic [DATA_WIDTH-1:0] out_din_r;

    logic [TAG_W-1:0]      in_tag_s;
    logic [OFF_W-1:0]      in_off_s;
    logic                  accept_s;
    logic                  hit_s;
    logic                  wr_hit_s;
    logic                  last_beat_s;
    logic                  st_we_s;
    logic [OFF_W-1:0]      st_waddr_s;
    logic [DATA_WIDTH-1:0] st_wdata_s;
    logic [OFF_W-1:0]      st_raddr_s;
    logic [DATA_WIDTH-1:0] st_rdata_s;
    logic [DATA_WIDTH-1:0] fill_dout_s;

    assign in_tag_s    = in_addr[ADDR_WIDTH-1:OFF_W];
    assign in_off_s    = in_addr[OFF_W-1:0];
    assign accept_s    = (state_r == IDLE) && in_wait_n_r;
    assign hit_s       = line_valid_r && (in_tag_s == tag_r) && !flush;
    assign wr_hit_s    = line_valid_r && (out_addr_r[ADDR_WIDTH-1:OFF_W] == tag_r);
    assign last_beat_s = out_valid && (cnt_r == OFF_W'(BURST_LEN - 1));
    assign st_raddr_s  = (state_r == RD_FILL) ? req_off_r : in_off_s;
    // The requested word may be the beat being written on the final edge.
    assign fill_dout_s = (req_off_r == cnt_r) ? out_dout : st_rdata_s;

    // Line store write-port steering: burst beats during fill, write-through patch on hit
    always_comb begin
        st_we_s    = 1'b0;
        st_waddr_s = cnt_r;
        st_wdata_s = out_dout;
        case (state_r)
            RD_FILL: begin
                if (out_valid) begin
                    st_we_s = 1'b1;
                end else begin
                    st_we_s = 1'b0;
                end
            end
            WR_REQ: begin
                st_waddr_s = out_addr_r[OFF_W-1:0];
                st_wdata_s = out_din_r;
                if (out_wait_n && wr_hit_s) begin
                    st_we_s = 1'b1;
                end else begin
                    st_we_s = 1'b0;
                end
            end
            default: begin
                st_we_s = 1'b0;
            end
        endcase
    end

    line_read_buffer_line_store #(
        .DEPTH      (BURST_LEN),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (OFF_W)
    ) u_line_store (
        .clock (clock),
        .we    (st_we_s),
        .waddr (st_waddr_s),
        .wdata (st_wdata_s),
        .raddr (st_raddr_s),
        .rdata (st_rdata_s)
    );

    // Control FSM with registered upstream and downstream outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            line_valid_r <= 1'b0;
            flush_pend_r <= 1'b0;
            tag_r        <= '0;
            req_tag_r    <= '0;
            req_off_r    <= '0;
            cnt_r        <= '0;
            in_dout_r    <= '0;
            in_wait_n_r  <= 1'b0;
            in_valid_r   <= 1'b0;
            out_rd_r     <= 1'b0;
            out_wr_r     <= 1'b0;
            out_addr_r   <= '0;
            out_din_r    <= '0;
        end else begin
            in_valid_r <= 1'b0;
            if (flush) begin
                line_valid_r <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    in_wait_n_r <= 1'b1;
                    if (accept_s && in_wr) begin
                        state_r     <= WR_REQ;
                        out_wr_r    <= 1'b1;
                        out_addr_r  <= in_addr;
                        out_din_r   <= in_din;
                        in_wait_n_r <= 1'b0;
                    end else if (accept_s && in_rd) begin
                        if (hit_s) begin
                            in_valid_r <= 1'b1;
                            in_dout_r  <= st_rdata_s;
                        end else begin
                            // Line contents are about to be overwritten by the burst.
                            state_r      <= RD_REQ;
                            out_rd_r     <= 1'b1;
                            out_addr_r   <= {in_tag_s, {OFF_W{1'b0}}};
                            req_tag_r    <= in_tag_s;
                            req_off_r    <= in_off_s;
                            line_valid_r <= 1'b0;
                            flush_pend_r <= 1'b0;
                            in_wait_n_r  <= 1'b0;
                        end
                    end
                end
                RD_REQ: begin
                    if (flush) begin
                        flush_pend_r <= 1'b1;
                    end
                    if (out_wait_n) begin
                        state_r  <= RD_FILL;
                        out_rd_r <= 1'b0;
                        cnt_r    <= '0;
                    end
                end
                RD_FILL: begin
                    if (flush) begin
                        flush_pend_r <= 1'b1;
                    end
                    if (out_valid) begin
                        cnt_r <= cnt_r + OFF_W'(1);
                        if (last_beat_s) begin
                            state_r      <= IDLE;
                            tag_r        <= req_tag_r;
                            line_valid_r <= !(flush_pend_r || flush);
                            in_wait_n_r  <= 1'b1;
                            in_valid_r   <= 1'b1;
                            in_dout_r    <= fill_dout_s;
                        end
                    end
                end
                WR_REQ: begin
                    if (out_wait_n) begin
                        state_r     <= IDLE;
                        out_wr_r    <= 1'b0;
                        in_wait_n_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_wait_n_r <= 1'b0;
                    out_rd_r    <= 1'b0;
                    out_wr_r    <= 1'b0;
                end
            endcase
        end
    end

    assign in_dout   = in_dout_r;
    assign in_wait_n = in_wait_n_r;
    assign in_valid  = in_valid_r;
    assign out_rd    = out_rd_r;
    assign out_wr    = out_wr_r;
    assign out_addr  = out_addr_r;
    assign out_din   = out_din_r;

endmodule

// File: tb/tb_line_read_buffer.sv
// Directed bench for line_read_buffer: a cycle table for fill, hits and
// write-through, then hand-written flush, reset and boundary sequences.
module tb_line_read_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_rd;
    logic        in_wr;
    logic [6:0]  in_addr;
    logic [15:0] in_din;
    logic [15:0] in_dout;
    logic        in_wait_n;
    logic        in_valid;
    logic        out_rd;
    logic        out_wr;
    logic [6:0]  out_addr;
    logic [15:0] out_din;
    logic [15:0] out_dout;
    logic        out_wait_n;
    logic        out_valid;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    line_read_buffer #(.ADDR_WIDTH(7), .DATA_WIDTH(16), .BURST_LEN(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .in_rd      (in_rd),
        .in_wr      (in_wr),
        .in_addr    (in_addr),
        .in_din     (in_din),
        .in_dout    (in_dout),
        .in_wait_n  (in_wait_n),
        .in_valid   (in_valid),
        .out_rd     (out_rd),
        .out_wr     (out_wr),
        .out_addr   (out_addr),
        .out_din    (out_din),
        .out_dout   (out_dout),
        .out_wait_n (out_wait_n),
        .out_valid  (out_valid)
    );

    // inputs applied during a cycle, and outputs expected during that same cycle
    typedef struct {
        logic        rd, wr, fl, ow, ov;
        logic [6:0]  addr;
        logic [15:0] din, od;
        logic        wn, v;
        logic [15:0] dout;
        logic        ord, owr;
        logic [6:0]  oaddr;
        logic [15:0] odin;
    } vec_t;

    vec_t tbl [25];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic request(input string name, input logic rd, input logic wr,
                           input logic [6:0] a, input logic [15:0] d);
        int n = 0;
        in_rd = rd; in_wr = wr; in_addr = a; in_din = d;
        @(negedge clock);
        while (!in_wait_n && n < 20) begin
            @(posedge clock); #1; @(negedge clock); n++;
        end
        check({name, "_accept"}, 64'(in_wait_n), 64'd1);
        @(posedge clock); #1;
        in_rd = 1'b0; in_wr = 1'b0;
    endtask

    task automatic serve(input string name, input logic [6:0] base,
                         input logic [15:0] d0, input logic [15:0] d1,
                         input logic [15:0] d2, input logic [15:0] d3,
                         input int off, input int fl_beat);
        logic [15:0] beats [4];
        int n = 0;
        beats[0] = d0; beats[1] = d1; beats[2] = d2; beats[3] = d3;
        @(negedge clock);
        while (!out_rd && n < 20) begin
            @(posedge clock); #1; @(negedge clock); n++;
        end
        check({name, "_out_rd"}, 64'(out_rd), 64'd1);
        check({name, "_base"}, 64'(out_addr), 64'(base));
        out_wait_n = 1'b1;
        @(posedge clock); #1;
        out_wait_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            out_valid = 1'b1;
            out_dout  = beats[i];
            flush     = (i == fl_beat);
            @(posedge clock); #1;
        end
        out_valid = 1'b0;
        flush     = 1'b0;
        @(negedge clock);
        check({name, "_data"}, 64'({in_valid, in_dout}), 64'({1'b1, beats[off]}));
        @(posedge clock); #1; @(negedge clock);
        check({name, "_one_strobe"}, 64'(in_valid), 64'd0);
        @(posedge clock); #1;
    endtask

    task automatic hit(input string name, input logic [6:0] a, input logic [15:0] exp);
        request(name, 1'b1, 1'b0, a, 16'h0000);
        @(negedge clock);
        check({name, "_hit"}, 64'({in_valid, in_dout, out_rd}), 64'({1'b1, exp, 1'b0}));
        @(posedge clock); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // rd wr fl ow ov addr din od | wn v dout ord owr oaddr odin
        tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,7'h00,16'h0000,16'h0000, 1'b0,1'b0,16'h0000,1'b0,1'b0,7'h00,16'h0000};
        tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,7'h05,16'h0000,16'h0000, 1'b1,1'b0,16'h0000,1'b0,1'b0,7'h00,16'h0000};
        tbl[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,7'h00,16'h0000,16'h0000, 1'b0,1'b0,16'h0000,1'b1,1'b0,7'h04,16'h0000};
        tbl[3]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,7'h00,16'h0000,16'h0000, 1'b0,1'b0,16'h0000,1'b1,1'b0,7'h04,16'h0000};
        tbl[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,7'h00,16'h0000,16'h1111, 1'b0,1'b0,16'h0000,1'b0,1'b0,7'h04,16'h0000};
        tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,7'h00,16'h0000,16'h2222, 1'b0,1'b0,16'h0000,1'b0,1'b0,7'h04,16'h0000};
        tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,7'h00,16'h0000,16'h3333, 1'b0,1'b0,16'h0000,1'b0,1'b0,7'h04,16'h0000};
        tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,7'h00,16'h0000,16'h4444, 1'b0,1'b0,16'h0000,1'b0,1'b0,7'h04,16'h0000};
        tbl[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,7'h06,16'h0000,16'h0000, 1'b1,1'b1,16'h2222,1'b0,1'b0,7'h04,16'h0000};
        tbl[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,7'h07,16'h0000,16'h0000, 1'b1,1'b1,16'h3333,1'b0,1'b0,7'h04,16'h0000};
        tbl[10] = '{1'b1,1'b0,1'b0,1'b0,1'b0,7'h04,16'h0000,16'h0000, 1'b1,1'b1,16'h4444,1'b0,1'b0,7'h04,16'h0000};
        tbl[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0,7'h00,16'h0000,16'h0000, 1'b1,1'b1,16'h1111,1'b0,1'b0,7'h04,16'h0000};
        tbl[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,7'h00,16'h0000,16'h0000, 1'b1,1'b0,16'h1111,1'b0,1'b0,7'h04,16'h0000};
        tbl[13] = '{1'b0,1'b1,1'b0,1'b0,1'b0,7'h07,16'hABCD,16'h0000, 1'b1,1'b0,16'h1111,1'b0,1'b0,7'h04,16'h0000};
        tbl[14] = '{1'b0,1'b0,1'b0,1'b0,1'b0,7'h00,16'h0000,16'h0000, 1'b0,1'b0,16'h1111,1'b0,1'b1,7'h07,16'hABCD};
        tbl[15] = '{1'b0,1'b0,1'b0,1'b0,1'b0,7'h00,16'h0000,16'h0000, 1'b0,1'b0,16'h1111,1'b0,1'b1,7'h07,16'hABCD};
        tbl[16] = '{1'b0,1'b0,1'b0,1'b0,1'b0,7'h00,16'h0000,16'h0000, 1'b0,1'b0,16'h1111,1'b0,1'b1,7'h07,16'hABCD};
        tbl[17] = '{1'b0,1'b0,1'b0,1'b1,1'b0,7'h00,16'h0000,16'h0000, 1'b0,1'b0,16'h1111,1'b0,1'b1,7'h07,16'hABCD};
        tbl[18] = '{1'b1,1'b0,1'b0,1'b0,1'b0,7'h07,16'h0000,16'h0000, 1'b1,1'b0,16'h1111,1'b0,1'b0,7'h07,16'hABCD};
        tbl[19] = '{1'b0,1'b1,1'b0,1'b0,1'b0,7'h10,16'h5555,16'h0000, 1'b1,1'b1,16'hABCD,1'b0,1'b0,7'h07,16'hABCD};
        tbl[20] = '{1'b0,1'b0,1'b0,1'b1,1'b0,7'h00,16'h0000,16'h0000, 1'b0,1'b0,16'hABCD,1'b0,1'b1,7'h10,16'h5555};
        tbl[21] = '{1'b1,1'b0,1'b0,1'b0,1'b0,7'h04,16'h0000,16'h0000, 1'b1,1'b0,16'hABCD,1'b0,1'b0,7'h10,16'h5555};
        tbl[22] = '{1'b1,1'b0,1'b0,1'b0,1'b0,7'h07,16'h0000,16'h0000, 1'b1,1'b1,16'h1111,1'b0,1'b0,7'h10,16'h5555};
        tbl[23] = '{1'b0,1'b0,1'b0,1'b0,1'b0,7'h00,16'h0000,16'h0000, 1'b1,1'b1,16'hABCD,1'b0,1'b0,7'h10,16'h5555};
        tbl[24] = '{1'b0,1'b0,1'b0,1'b0,1'b0,7'h00,16'h0000,16'h0000, 1'b1,1'b0,16'hABCD,1'b0,1'b0,7'h10,16'h5555};

        reset = 1'b1; flush = 1'b0; in_rd = 1'b0; in_wr = 1'b0;
        in_addr = 7'h00; in_din = 16'h0000;
        out_dout = 16'h0000; out_wait_n = 1'b0; out_valid = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        check("reset_outputs",
              64'({in_dout, in_wait_n, in_valid, out_rd, out_wr, out_addr, out_din}), 64'd0);
        reset = 1'b0;

        // Cold miss, back-to-back hits, stalled write-through, non-matching write
        for (int i = 0; i < 25; i++) begin
            in_rd = tbl[i].rd; in_wr = tbl[i].wr; flush = tbl[i].fl;
            out_wait_n = tbl[i].ow; out_valid = tbl[i].ov;
            in_addr = tbl[i].addr; in_din = tbl[i].din; out_dout = tbl[i].od;
            @(negedge clock);
            check($sformatf("row%0d", i),
                  64'({in_wait_n, in_valid, in_dout, out_rd, out_wr, out_addr, out_din}),
                  64'({tbl[i].wn, tbl[i].v, tbl[i].dout, tbl[i].ord, tbl[i].owr, tbl[i].oaddr, tbl[i].odin}));
            @(posedge clock); #1;
        end
        in_rd = 1'b0; in_wr = 1'b0; flush = 1'b0;
        out_wait_n = 1'b0; out_valid = 1'b0;

        // Flush in idle forces a refetch; flush during fill still answers but invalidates
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        request("t4_rd04", 1'b1, 1'b0, 7'h04, 16'h0000);
        serve("t4_fill", 7'h04, 16'h5001, 16'h5002, 16'h5003, 16'h5004, 0, -1);
        hit("t4_rd05", 7'h05, 16'h5002);
        request("t4_rd09", 1'b1, 1'b0, 7'h09, 16'h0000);
        serve("t4_flushfill", 7'h08, 16'h6001, 16'h6002, 16'h6003, 16'h6004, 1, 2);
        request("t4_rd0a", 1'b1, 1'b0, 7'h0A, 16'h0000);
        serve("t4_refetch", 7'h08, 16'h7001, 16'h7002, 16'h7003, 16'h7004, 2, -1);

        // Reset in the middle of a burst; trailing beats must be ignored
        request("t5_rd05", 1'b1, 1'b0, 7'h05, 16'h0000);
        begin
            int n = 0;
            @(negedge clock);
            while (!out_rd && n < 20) begin
                @(posedge clock); #1; @(negedge clock); n++;
            end
            check("t5_out_rd", 64'(out_rd), 64'd1);
            out_wait_n = 1'b1;
            @(posedge clock); #1;
            out_wait_n = 1'b0;
            out_valid = 1'b1; out_dout = 16'hAAAA;
            @(posedge clock); #1;
            out_dout = 16'hBBBB;
            @(posedge clock); #1;
            out_valid = 1'b0;
            reset = 1'b1;
            @(posedge clock); #1;
            reset = 1'b0;
            check("t5_reset_outputs",
                  64'({in_dout, in_wait_n, in_valid, out_rd, out_wr, out_addr, out_din}), 64'd0);
            out_valid = 1'b1; out_dout = 16'hCCCC;
            @(posedge clock); #1;
            out_dout = 16'hDDDD;
            @(posedge clock); #1;
            out_valid = 1'b0;
            @(negedge clock);
            check("t5_stale_beats", 64'({in_valid, out_rd, out_wr}), 64'd0);
            @(posedge clock); #1;
        end
        request("t5_rd0a", 1'b1, 1'b0, 7'h0A, 16'h0000);
        serve("t5_line_invalid", 7'h08, 16'hF001, 16'hF002, 16'hF003, 16'hF004, 2, -1);
        request("t5_rd05b", 1'b1, 1'b0, 7'h05, 16'h0000);
        serve("t5_fresh", 7'h04, 16'hE001, 16'hE002, 16'hE003, 16'hE004, 1, -1);

        // Top-of-memory line, then simultaneous read+write where the write wins
        request("t6_rd7f", 1'b1, 1'b0, 7'h7F, 16'h0000);
        serve("t6_fill", 7'h7C, 16'h9001, 16'h9002, 16'h9003, 16'h9004, 3, -1);
        request("t6_rw", 1'b1, 1'b1, 7'h20, 16'hBEEF);
        @(negedge clock);
        check("t6_rw_issue", 64'({out_wr, out_rd, in_valid, out_addr, out_din}),
              64'({1'b1, 1'b0, 1'b0, 7'h20, 16'hBEEF}));
        out_wait_n = 1'b1;
        @(posedge clock); #1;
        out_wait_n = 1'b0;
        @(negedge clock);
        check("t6_rw_done", 64'({in_valid, out_wr, out_rd, in_wait_n}), 64'({1'b0, 1'b0, 1'b0, 1'b1}));
        @(posedge clock); #1;
        hit("t6_keep", 7'h7E, 16'h9003);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
